// File: rtl/msb_scan_ctrl.sv
// ---------------------------------------------------------------------------
// msb_scan_ctrl
//
// Multi-cycle leading-one scanner. When start is accepted in IDLE, the input
// vector is captured into a shadow register. The scanner then examines one
// bit per clock, starting at the MSB and moving towards the LSB. It reports
// whether any bit was set and, if so, the index of the highest set bit.
// The result is registered, is valid in the single done cycle, and holds
// until the next accepted start.
//
// Build option (macro MSB_SCAN_POPCOUNT_EN):
//   undefined : the scan ends at the first hit; count is tied to 0 and no
//               accumulator exists.
//   defined   : the scan always covers all WIDTH bits; count holds the
//               number of set bits; index still records the highest hit.
//
// Parameters:
//   WIDTH  scanned vector width, legal range 2..64
//   IDX_W  derived index width, $clog2(WIDTH); cannot be overridden
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        scan request, sampled only in IDLE
//   vec    in   WIDTH    vector to scan, captured on the accepted start
//   abort  in   1        cancels a scan in progress (SCAN state only)
//   busy   out  1        high whenever the FSM is not in IDLE
//   done   out  1        one-cycle pulse, result valid
//   found  out  1        at least one bit of the captured vector was set
//   index  out  IDX_W    index of the highest set bit, 0 when found=0
//   count  out  IDX_W+1  population count (0 unless the macro is defined)
// ---------------------------------------------------------------------------
module msb_scan_ctrl #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] vec,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] index_q, index_d;

`ifdef MSB_SCAN_POPCOUNT_EN
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(WIDTH);
    logic [IDX_W:0]   count_q, count_d;
`endif

    logic bit_hit;    // bit currently under the pointer is set
    logic ptr_zero;   // pointer is at the LSB
    logic scan_last;  // this SCAN cycle is the final one

    assign bit_hit  = shadow_q[ptr_q];
    assign ptr_zero = (ptr_q == '0);

`ifdef MSB_SCAN_POPCOUNT_EN
    // Full sweep: only reaching the LSB ends the scan.
    assign scan_last = ptr_zero;
`else
    // Early exit: the first hit ends the scan. A hit always happens while
    // found is still 0, because nothing before it was set.
    assign scan_last = bit_hit || ptr_zero;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // abort takes priority over a hit in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                end else if (scan_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            ptr_q    <= '0;
            found_q  <= 1'b0;
            index_q  <= '0;
`ifdef MSB_SCAN_POPCOUNT_EN
            count_q  <= '0;
`endif
        end else begin
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            found_q  <= found_d;
            index_q  <= index_d;
`ifdef MSB_SCAN_POPCOUNT_EN
            count_q  <= count_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        found_d  = found_q;
        index_d  = index_q;
`ifdef MSB_SCAN_POPCOUNT_EN
        count_d  = count_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = vec;
                    ptr_d    = PTR_MAX;
                    found_d  = 1'b0;
                    index_d  = '0;
`ifdef MSB_SCAN_POPCOUNT_EN
                    count_d  = '0;
`endif
                end
            end
            S_SCAN: begin
                if (abort) begin
                    found_d = 1'b0;
                    index_d = '0;
`ifdef MSB_SCAN_POPCOUNT_EN
                    count_d = '0;
`endif
                end else begin
                    // Only the first hit is recorded, which is the highest
                    // set bit because the walk runs MSB to LSB.
                    if (bit_hit && !found_q) begin
                        found_d = 1'b1;
                        index_d = ptr_q;
                    end
`ifdef MSB_SCAN_POPCOUNT_EN
                    if (bit_hit && (count_q != CNT_MAX)) begin
                        count_d = count_q + (IDX_W + 1)'(1);
                    end
`endif
                    // The pointer stays put on the final cycle, so it never
                    // wraps below zero.
                    if (!scan_last) begin
                        ptr_d = ptr_q - IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                // The results hold until the next accepted start.
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        busy  = (state_q != S_IDLE);
        done  = (state_q == S_DONE);
        found = found_q;
        index = index_q;
`ifdef MSB_SCAN_POPCOUNT_EN
        count = count_q;
`else
        count = '0;
`endif
    end

endmodule

// File: tb/tb_msb_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msb_scan_ctrl
//
// Directed testbench for msb_scan_ctrl with WIDTH=8. It covers both builds:
// when MSB_SCAN_POPCOUNT_EN is defined, the expected latency is always 9
// cycles and count must match the population count of the captured vector.
//
// Latency convention: start is accepted at edge T. A done seen during the
// interval (edge c, edge c+1) counts as "done at c+1".
// ---------------------------------------------------------------------------
module tb_msb_scan_ctrl;

`ifdef MSB_SCAN_POPCOUNT_EN
    localparam bit POP = 1'b1;
`else
    localparam bit POP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] vec   = '0;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] index;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_prev   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msb_scan_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .vec   (vec),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .found (found),
        .index (index),
        .count (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a vector with start high for one edge. On return, the
    // current time is just after the accepting edge T.
    task automatic launch(input logic [7:0] v);
        vec   = v;
        start = 1'b1;
        tick();
        start   = 1'b0;
        t_start = cyc;
    endtask

    // Waits, with a bound, for done and checks its latency relative to T.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = cyc - t_start + 1;
                break;
            end
            tick();
        end
        chk(tag, lat, exp_lat);
    endtask

    task automatic chk_res(input string tag, input logic f, input logic [2:0] i,
                           input logic [3:0] c);
        chk({tag, "_found"}, found, f);
        chk({tag, "_index"}, index, i);
        chk({tag, "_count"}, count, POP ? c : 4'd0);
    endtask

    initial begin
        int seen;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_index", index, 3'd0);
        chk("rst_count", count, 4'd0);
        rst_n = 1'b1;
        tick();

        // Early hit at bit 5
        launch(8'b0010_0100);
        chk("early_busy_rise", busy, 1'b1);
        wait_done("early_lat", POP ? 9 : 4);
        chk_res("early", 1'b1, 3'd5, 4'd2);
        tick();
        chk("early_done_pulse", done, 1'b0);
        chk("early_busy_fall", busy, 1'b0);
        chk_res("early_hold", 1'b1, 3'd5, 4'd2);

        // No bit set
        launch(8'h00);
        wait_done("zero_lat", 9);
        chk_res("zero", 1'b0, 3'd0, 4'd0);
        tick();
        chk("zero_busy_fall", busy, 1'b0);

        // MSB hit, then a back-to-back start on the LSB
        launch(8'h80);
        wait_done("msb_lat", POP ? 9 : 2);
        chk_res("msb", 1'b1, 3'd7, 4'd1);
        tick();
        chk("msb_busy_fall", busy, 1'b0);
        t_prev = t_start;
        launch(8'h01);
        chk("b2b_spacing", t_start - t_prev, POP ? 10 : 3);
        wait_done("lsb_lat", 9);
        chk_res("lsb", 1'b1, 3'd0, 4'd1);
        tick();
        chk("lsb_busy_fall", busy, 1'b0);

        // Abort at T+3; a start in the same cycle is ignored
        launch(8'h01);
        tick();
        tick();
        abort = 1'b1;
        start = 1'b1;
        vec   = 8'h80;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk_res("abort", 1'b0, 3'd0, 4'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1;
            tick();
        end
        chk("abort_no_activity", seen, 0);

        // Abort in the same cycle as a hit: the abort wins
        launch(8'h80);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_hit_busy", busy, 1'b0);
        chk("abort_hit_done", done, 1'b0);
        chk_res("abort_hit", 1'b0, 3'd0, 4'd0);
        tick();

        // Vector changes after capture; start during SCAN is ignored
        launch(8'h10);
        vec   = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("cap_lat", POP ? 9 : 5);
        chk_res("cap", 1'b1, 3'd4, 4'd1);
        tick();
        chk("cap_busy_fall", busy, 1'b0);
        tick();
        chk("cap_no_requeue", busy, 1'b0);

        // Full vector: count saturates at WIDTH
        launch(8'hFF);
        wait_done("full_lat", POP ? 9 : 2);
        chk_res("full", 1'b1, 3'd7, 4'd8);
        tick();

        // Reset mid-scan at T+2
        launch(8'h02);
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstscan_busy", busy, 1'b0);
        chk("rstscan_found", found, 1'b0);
        chk("rstscan_index", index, 3'd0);
        #3;
        rst_n = 1'b1;
        tick();

        // Reset during DONE, while the result is non-zero
        launch(8'h80);
        wait_done("rstdone_lat", POP ? 9 : 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstdone_done", done, 1'b0);
        chk("rstdone_busy", busy, 1'b0);
        chk_res("rstdone", 1'b0, 3'd0, 4'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // Normal scan after reset release
        launch(8'h40);
        wait_done("post_rst_lat", POP ? 9 : 3);
        chk_res("post_rst", 1'b1, 3'd6, 4'd1);
        tick();
        chk("post_rst_busy_fall", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
